// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw asynchronous key inputs in, debounced levels and
// one-cycle command pulses out. master = key source/consumer, slave = conditioner.
interface key_conditioner_if #(
  parameter int N = 4
);
  logic [N-1:0] in;
  logic [N-1:0] level;
  logic [N-1:0] pulse;
  logic         any_pulse;

  modport master (output in, input level, pulse, any_pulse);
  modport slave  (input in, output level, pulse, any_pulse);
endinterface

// File: rtl/key_conditioner.sv
// N-channel push-button front end: 2-FF sync, counter debounce, edge pulse.
// Optional auto-repeat of held keys when KEY_REPEAT_EN is defined.
module key_conditioner #(
  parameter int N          = 4,
  parameter int DB_CYCLES  = 1000,
  parameter int EDGE_MODE  = 0,
  parameter int REP_DELAY  = 5000,
  parameter int REP_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             r,
  key_conditioner_if.slave kif
);

  localparam int            CW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DB_CYCLES - 1);

  logic [N-1:0] w_level;
  logic [N-1:0] w_pulse;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic          r_s1;
      logic          r_s2;
      logic [CW-1:0] r_cnt;
      logic          r_level;
      logic          r_pulse;
      logic          w_flip;
      logic          w_match;
      logic          w_rep;

      assign w_flip = (r_s2 != r_level) && (r_cnt == C_LAST);

      // r_s2 is the level being adopted on a flip
      always_comb begin
        w_match = r_s2;
        case (EDGE_MODE)
          1:       w_match = ~r_s2;
          2:       w_match = 1'b1;
          default: w_match = r_s2;
        endcase
      end

`ifdef KEY_REPEAT_EN
      localparam int            RW      = $clog2(REP_DELAY + REP_PERIOD + 1);
      localparam logic [RW-1:0] RC_DLY  = RW'(REP_DELAY);
      localparam logic [RW-1:0] RC_WRAP = RW'(REP_DELAY + REP_PERIOD);

      logic [RW-1:0] r_rc;
      logic [RW-1:0] w_rc_inc;

      assign w_rc_inc = r_rc + 1'b1;
      assign w_rep    = r_level && ((w_rc_inc == RC_DLY) || (w_rc_inc == RC_WRAP));

      // Folding back to REP_DELAY keeps later repeats REP_PERIOD apart forever
      always_ff @(posedge clk) begin
        if (r || w_flip || !r_level) begin
          r_rc <= '0;
        end else if (w_rc_inc == RC_WRAP) begin
          r_rc <= RC_DLY;
        end else begin
          r_rc <= w_rc_inc;
        end
      end
`else
      // repeat feature compiled out: never fires
      assign w_rep = (REP_DELAY < 0) && (REP_PERIOD < 0);
`endif

      always_ff @(posedge clk) begin
        if (r) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_pulse <= 1'b0;
        end else begin
          r_s1    <= kif.in[gi];
          r_s2    <= r_s1;
          // a flip outranks a repeat falling due in the same cycle
          r_pulse <= w_flip ? w_match : w_rep;
          if (r_s2 == r_level) begin
            r_cnt <= '0;
          end else if (w_flip) begin
            r_level <= r_s2;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_level[gi] = r_level;
      assign w_pulse[gi] = r_pulse;
    end
  endgenerate

  assign kif.level     = w_level;
  assign kif.pulse     = w_pulse;
  assign kif.any_pulse = |w_pulse;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: two instances (EDGE_MODE 0 and 2),
// N=2, DB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3; repeat checks follow KEY_REPEAT_EN.
module tb_key_conditioner;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  key_conditioner_if #(.N(2)) if0 ();
  key_conditioner_if #(.N(2)) if2 ();

  key_conditioner #(
    .N(2), .DB_CYCLES(4), .EDGE_MODE(0), .REP_DELAY(10), .REP_PERIOD(3)
  ) dut0 (
    .clk (clk),
    .r   (rst),
    .kif (if0)
  );

  key_conditioner #(
    .N(2), .DB_CYCLES(4), .EDGE_MODE(2), .REP_DELAY(10), .REP_PERIOD(3)
  ) dut2 (
    .clk (clk),
    .r   (rst),
    .kif (if2)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] p0_h [64];
  logic [1:0] l0_h [64];
  logic       a0_h [64];
  logic [1:0] p2_h [64];
  logic [1:0] l2_h [64];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive x0/x2 before edge 0, drop both to 0 before edge rel, record n edges.
  task automatic run(input logic [1:0] x0, input logic [1:0] x2, input int rel, input int n);
    if0.in = x0;
    if2.in = x2;
    for (int t = 0; t < n; t++) begin
      if (t == rel) begin
        if0.in = 2'b00;
        if2.in = 2'b00;
      end
      tick();
      p0_h[t] = if0.pulse;
      l0_h[t] = if0.level;
      a0_h[t] = if0.any_pulse;
      p2_h[t] = if2.pulse;
      l2_h[t] = if2.level;
    end
  endtask

  // Auto-repeat expected on a held key: flip at f, release flip at fr.
  function automatic bit exp_rep(input int t, input int f, input int fr);
    return REP_EN && (t >= f + 10) && (t < fr) && (((t - f - 10) % 3) == 0);
  endfunction

  initial begin
    rst    = 1'b1;
    if0.in = 2'b11;
    if2.in = 2'b11;

    // Test 1: reset held two edges, inputs high from power-up
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq($sformatf("t1_rst_level0_%0d", k), if0.level, 2'b00);
      check_eq($sformatf("t1_rst_pulse0_%0d", k), if0.pulse, 2'b00);
      check_eq($sformatf("t1_rst_any0_%0d", k), if0.any_pulse, 1'b0);
      check_eq($sformatf("t1_rst_level2_%0d", k), if2.level, 2'b00);
    end
    rst = 1'b0;
    run(2'b11, 2'b11, -1, 8);
    for (int t = 0; t < 8; t++) begin
      check_eq($sformatf("t1_level0_e%0d", t), l0_h[t], (t >= 5) ? 2'b11 : 2'b00);
      check_eq($sformatf("t1_pulse0_e%0d", t), p0_h[t], (t == 5) ? 2'b11 : 2'b00);
      check_eq($sformatf("t1_any0_e%0d", t), a0_h[t], t == 5);
      check_eq($sformatf("t1_pulse2_e%0d", t), p2_h[t], (t == 5) ? 2'b11 : 2'b00);
    end
    $display("test1: power-up press, checks=%0d errors=%0d", n_checks, n_errors);
    run(2'b00, 2'b00, -1, 10);

    // Test 2: single channel press held 20 cycles
    run(2'b01, 2'b00, 20, 30);
    for (int t = 0; t < 30; t++) begin
      check_eq($sformatf("t2_level_e%0d", t), l0_h[t], {1'b0, (t >= 5) && (t < 25)});
      check_eq($sformatf("t2_pulse_e%0d", t), p0_h[t], {1'b0, (t == 5) || exp_rep(t, 5, 25)});
    end
    $display("test2: held press, checks=%0d errors=%0d", n_checks, n_errors);
    run(2'b00, 2'b00, -1, 10);

    // Test 3: 3-cycle glitches rejected, 4-cycle press accepted
    for (int rep = 0; rep < 2; rep++) begin
      run(2'b01, 2'b00, 3, 10);
      for (int t = 0; t < 10; t++) begin
        check_eq($sformatf("t3_glitch%0d_level_e%0d", rep, t), l0_h[t], 2'b00);
        check_eq($sformatf("t3_glitch%0d_any_e%0d", rep, t), a0_h[t], 1'b0);
      end
    end
    run(2'b01, 2'b00, 4, 12);
    for (int t = 0; t < 12; t++) begin
      check_eq($sformatf("t3_min_level_e%0d", t), l0_h[t], {1'b0, (t >= 5) && (t < 9)});
      check_eq($sformatf("t3_min_pulse_e%0d", t), p0_h[t], {1'b0, t == 5});
    end
    $display("test3: glitch filter, checks=%0d errors=%0d", n_checks, n_errors);
    run(2'b00, 2'b00, -1, 10);

    // Test 4: EDGE_MODE=2 pulses on press and release
    run(2'b00, 2'b01, 10, 22);
    for (int t = 0; t < 22; t++) begin
      check_eq($sformatf("t4_level2_e%0d", t), l2_h[t], {1'b0, (t >= 5) && (t < 15)});
      check_eq($sformatf("t4_pulse2_e%0d", t), p2_h[t],
               {1'b0, (t == 5) || (t == 15) || exp_rep(t, 5, 15)});
      check_eq($sformatf("t4_pulse0_e%0d", t), p0_h[t], 2'b00);
    end
    $display("test4: both-edge mode, checks=%0d errors=%0d", n_checks, n_errors);
    run(2'b00, 2'b00, -1, 10);

    // Test 5: reset with debounce count at 2, key still pressed
    if0.in = 2'b01;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    check_eq("t5_rst_level", if0.level, 2'b00);
    check_eq("t5_rst_pulse", if0.pulse, 2'b00);
    check_eq("t5_rst_any", if0.any_pulse, 1'b0);
    rst = 1'b0;
    run(2'b01, 2'b00, -1, 8);
    for (int t = 0; t < 8; t++) begin
      check_eq($sformatf("t5_level_e%0d", t), l0_h[t], {1'b0, t >= 5});
      check_eq($sformatf("t5_pulse_e%0d", t), p0_h[t], {1'b0, t == 5});
    end
    $display("test5: mid-press reset, checks=%0d errors=%0d", n_checks, n_errors);
    run(2'b00, 2'b00, -1, 10);

    // Test 6: long hold, repeats only when the feature is built in
    run(2'b01, 2'b00, 30, 45);
    for (int t = 0; t < 45; t++) begin
      check_eq($sformatf("t6_level_e%0d", t), l0_h[t], {1'b0, (t >= 5) && (t < 35)});
      check_eq($sformatf("t6_pulse_e%0d", t), p0_h[t], {1'b0, (t == 5) || exp_rep(t, 5, 35)});
    end
    $display("test6: long hold repeat_en=%0d, checks=%0d errors=%0d", REP_EN, n_checks, n_errors);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
